snake_engine: RTL and testbench

Parametrised grid snake-game engine for the VGA game datapath, the successor to the two-segment head/body controller. It holds a variable-length snake of up to MAX_LEN segments, advances it one tile per move tick, grows it on apple contact, and detects self-collision (and optionally wall collision). A registered per-pixel tile query port lets the display logic ask "is tile (qx,qy) head/body" with fixed latency.

---
 rtl/snake_engine.sv | 271 +++++++++++++++++++++++++++
 tb/tb_snake_engine.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/snake_engine.sv
// snake_engine: grid snake-game engine with a variable-length body, apple growth,
// self/wall collision and a registered per-tile query. Define SNAKE_WRAP_EN to wrap at grid edges.
module snake_engine #(
  parameter int unsigned GRID_W  = 15,
  parameter int unsigned GRID_H  = 15,
  parameter int unsigned COORD_W = 4,
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned LEN_W   = 5
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               tick_i,
  input  logic               up_i,
  input  logic               down_i,
  input  logic               left_i,
  input  logic               right_i,
  input  logic [COORD_W-1:0] apple_x_i,
  input  logic [COORD_W-1:0] apple_y_i,
  input  logic               apple_valid_i,
  input  logic [COORD_W-1:0] qx_i,
  input  logic [COORD_W-1:0] qy_i,
  output logic               q_head_o,
  output logic               q_body_o,
  output logic [COORD_W-1:0] head_x_o,
  output logic [COORD_W-1:0] head_y_o,
  output logic [LEN_W-1:0]   length_o,
  output logic               ate_o,
  output logic               game_over_o,
  output logic               running_o
);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP_EN = 1'b1;
`else
  localparam bit WRAP_EN = 1'b0;
`endif

  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID_H - 1);
  localparam logic [COORD_W-1:0] X_START = COORD_W'(GRID_W / 2);
  localparam logic [COORD_W-1:0] Y_START = COORD_W'(GRID_H / 2);
  localparam logic [COORD_W:0]   GW_EXT  = (COORD_W + 1)'(GRID_W);
  localparam logic [COORD_W:0]   GH_EXT  = (COORD_W + 1)'(GRID_H);
  localparam logic [LEN_W-1:0]   LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]   LEN_RST = LEN_W'(2);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_OVER
  } state_e;

  typedef enum logic [1:0] {
    DIR_RIGHT,
    DIR_LEFT,
    DIR_UP,
    DIR_DOWN
  } dir_e;

  function automatic dir_e opposite(input dir_e d);
    dir_e r;
    case (d)
      DIR_RIGHT: r = DIR_LEFT;
      DIR_LEFT:  r = DIR_RIGHT;
      DIR_UP:    r = DIR_DOWN;
      default:   r = DIR_UP;
    endcase
    return r;
  endfunction

  state_e             state_q, state_d;
  dir_e               dir_q, dir_d;
  dir_e               pend_q, pend_d;
  logic [COORD_W-1:0] seg_x_q [MAX_LEN];
  logic [COORD_W-1:0] seg_x_d [MAX_LEN];
  logic [COORD_W-1:0] seg_y_q [MAX_LEN];
  logic [COORD_W-1:0] seg_y_d [MAX_LEN];
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ate_q, ate_d;
  logic               over_q, over_d;
  logic               run_q, run_d;
  logic               q_head_q, q_head_d;
  logic               q_body_q, q_body_d;

  logic               btn_any;
  dir_e               btn_dir;
  logic [COORD_W-1:0] nxt_x, nxt_y;
  logic               wall_hit;
  logic               eat, grow, self_hit;
  logic [LEN_W-1:0]   chk_len;
  logic               q_in_grid;

  // Button decode with fixed priority right > left > up > down.
  always_comb begin
    btn_any = up_i | down_i | left_i | right_i;
    btn_dir = DIR_RIGHT;
    if (right_i) begin
      btn_dir = DIR_RIGHT;
    end else if (left_i) begin
      btn_dir = DIR_LEFT;
    end else if (up_i) begin
      btn_dir = DIR_UP;
    end else if (down_i) begin
      btn_dir = DIR_DOWN;
    end
  end

  // Candidate head one tile along the pending direction; the wrapped tile is used only when wrap is enabled.
  always_comb begin
    nxt_x    = seg_x_q[0];
    nxt_y    = seg_y_q[0];
    wall_hit = 1'b0;
    case (pend_q)
      DIR_RIGHT: begin
        if (seg_x_q[0] == X_MAX) begin
          nxt_x    = '0;
          wall_hit = 1'b1;
        end else begin
          nxt_x = seg_x_q[0] + COORD_W'(1);
        end
      end
      DIR_LEFT: begin
        if (seg_x_q[0] == '0) begin
          nxt_x    = X_MAX;
          wall_hit = 1'b1;
        end else begin
          nxt_x = seg_x_q[0] - COORD_W'(1);
        end
      end
      DIR_UP: begin
        if (seg_y_q[0] == '0) begin
          nxt_y    = Y_MAX;
          wall_hit = 1'b1;
        end else begin
          nxt_y = seg_y_q[0] - COORD_W'(1);
        end
      end
      default: begin
        if (seg_y_q[0] == Y_MAX) begin
          nxt_y    = '0;
          wall_hit = 1'b1;
        end else begin
          nxt_y = seg_y_q[0] + COORD_W'(1);
        end
      end
    endcase
  end

  // Eat/grow decision and self-collision; the tail is excluded unless the snake grows this move.
  always_comb begin
    eat      = apple_valid_i && (nxt_x == apple_x_i) && (nxt_y == apple_y_i);
    grow     = eat && (len_q < LEN_MAX);
    chk_len  = grow ? len_q : (len_q - LEN_W'(1));
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < chk_len) && (seg_x_q[i] == nxt_x) && (seg_y_q[i] == nxt_y)) begin
        self_hit = 1'b1;
      end
    end
  end

  // Tile query against the live segments; off-grid coordinates never match.
  always_comb begin
    q_in_grid = ({1'b0, qx_i} < GW_EXT) && ({1'b0, qy_i} < GH_EXT);
    q_head_d  = q_in_grid && (seg_x_q[0] == qx_i) && (seg_y_q[0] == qy_i);
    q_body_d  = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((LEN_W'(i) < len_q) && (seg_x_q[i] == qx_i) && (seg_y_q[i] == qy_i)) begin
        q_body_d = 1'b1;
      end
    end
    q_body_d = q_body_d && q_in_grid;
  end

  // Game FSM, direction commit and segment shift.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pend_d  = pend_q;
    seg_x_d = seg_x_q;
    seg_y_d = seg_y_q;
    len_d   = len_q;
    ate_d   = 1'b0;

    if (btn_any && (btn_dir != opposite(dir_q))) begin
      pend_d = btn_dir;
    end

    case (state_q)
      ST_IDLE: begin
        if (btn_any) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (tick_i) begin
          dir_d = pend_q;
          if (self_hit || (wall_hit && !WRAP_EN)) begin
            state_d = ST_OVER;
          end else begin
            for (int i = 1; i < MAX_LEN; i++) begin
              seg_x_d[i] = seg_x_q[i-1];
              seg_y_d[i] = seg_y_q[i-1];
            end
            seg_x_d[0] = nxt_x;
            seg_y_d[0] = nxt_y;
            if (grow) begin
              len_d = len_q + LEN_W'(1);
            end
            ate_d = eat;
          end
        end
      end
      ST_OVER: begin
        state_d = ST_OVER;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    run_d  = (state_d == ST_RUN);
    over_d = (state_d == ST_OVER);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_IDLE;
      dir_q    <= DIR_RIGHT;
      pend_q   <= DIR_RIGHT;
      len_q    <= LEN_RST;
      ate_q    <= 1'b0;
      over_q   <= 1'b0;
      run_q    <= 1'b0;
      q_head_q <= 1'b0;
      q_body_q <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= '0;
        seg_y_q[i] <= '0;
      end
      seg_x_q[0] <= X_START;
      seg_y_q[0] <= Y_START;
      seg_x_q[1] <= X_START - COORD_W'(1);
      seg_y_q[1] <= Y_START;
    end else begin
      state_q  <= state_d;
      dir_q    <= dir_d;
      pend_q   <= pend_d;
      len_q    <= len_d;
      ate_q    <= ate_d;
      over_q   <= over_d;
      run_q    <= run_d;
      q_head_q <= q_head_d;
      q_body_q <= q_body_d;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= seg_x_d[i];
        seg_y_q[i] <= seg_y_d[i];
      end
    end
  end

  assign q_head_o    = q_head_q;
  assign q_body_o    = q_body_q;
  assign head_x_o    = seg_x_q[0];
  assign head_y_o    = seg_y_q[0];
  assign length_o    = len_q;
  assign ate_o       = ate_q;
  assign game_over_o = over_q;
  assign running_o   = run_q;

endmodule

// File: tb/tb_snake_engine.sv
// Bench for snake_engine: directed scenarios plus randomized play, checked every cycle
// against a queue-based snake model.
module tb_snake_engine;
  localparam int GW = 15;
  localparam int GH = 15;
  localparam int CW = 4;
  localparam int ML = 16;
  localparam int LW = 5;

  logic          clk = 1'b0;
  logic          rst_n, tick, b_up, b_down, b_left, b_right, av;
  logic [CW-1:0] ax, ay, qx, qy;
  logic          q_head, q_body, ate, game_over, running;
  logic [CW-1:0] head_x, head_y;
  logic [LW-1:0] length;

  int checks = 0;
  int errors = 0;

  // Model: snake as a queue of tiles (front = head), direction as unit vectors.
  int mx[$];
  int my[$];
  bit m_run, m_over;
  bit e_ate, e_qh, e_qb;
  int cdx, cdy, pdx, pdy;

  always #5 clk = ~clk;

  snake_engine #(
    .GRID_W(GW), .GRID_H(GH), .COORD_W(CW), .MAX_LEN(ML), .LEN_W(LW)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .tick_i(tick),
    .up_i(b_up), .down_i(b_down), .left_i(b_left), .right_i(b_right),
    .apple_x_i(ax), .apple_y_i(ay), .apple_valid_i(av),
    .qx_i(qx), .qy_i(qy),
    .q_head_o(q_head), .q_body_o(q_body),
    .head_x_o(head_x), .head_y_o(head_y), .length_o(length),
    .ate_o(ate), .game_over_o(game_over), .running_o(running)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mx = '{7, 6};
    my = '{7, 7};
    m_run = 1'b0; m_over = 1'b0;
    cdx = 1; cdy = 0; pdx = 1; pdy = 0;
    e_ate = 1'b0; e_qh = 1'b0; e_qb = 1'b0;
  endtask

  task automatic model_step();
    int  bdx, bdy, nx, ny, ocdx, ocdy;
    bit  bany, wall, eat, grow, hit;
    if (!rst_n) begin
      model_reset();
      return;
    end
    ocdx = cdx; ocdy = cdy;
    e_qh = 1'b0; e_qb = 1'b0;
    if (qx < GW && qy < GH) begin
      for (int k = 0; k < mx.size(); k++) begin
        if (mx[k] == int'(qx) && my[k] == int'(qy)) begin
          if (k == 0) e_qh = 1'b1;
          else        e_qb = 1'b1;
        end
      end
    end
    e_ate = 1'b0;
    bany = b_up | b_down | b_left | b_right;
    bdx = 0; bdy = 0;
    if (b_right)     begin bdx = 1;  bdy = 0;  end
    else if (b_left) begin bdx = -1; bdy = 0;  end
    else if (b_up)   begin bdx = 0;  bdy = -1; end
    else if (b_down) begin bdx = 0;  bdy = 1;  end
    if (!m_run && !m_over) begin
      if (bany) m_run = 1'b1;
    end else if (m_run && tick) begin
      nx = mx[0] + pdx;
      ny = my[0] + pdy;
      wall = (nx < 0) || (nx >= GW) || (ny < 0) || (ny >= GH);
`ifdef SNAKE_WRAP_EN
      nx = (nx + GW) % GW;
      ny = (ny + GH) % GH;
      wall = 1'b0;
`endif
      eat  = av && (nx == int'(ax)) && (ny == int'(ay));
      grow = eat && (mx.size() < ML);
      hit  = 1'b0;
      for (int k = 0; k < mx.size(); k++) begin
        if ((k < mx.size() - 1 || grow) && mx[k] == nx && my[k] == ny) hit = 1'b1;
      end
      cdx = pdx; cdy = pdy;
      if (wall || hit) begin
        m_run = 1'b0; m_over = 1'b1;
      end else begin
        mx.push_front(nx);
        my.push_front(ny);
        if (!grow) begin
          void'(mx.pop_back());
          void'(my.pop_back());
        end
        e_ate = eat;
      end
    end
    if (bany && !(bdx == -ocdx && bdy == -ocdy)) begin
      pdx = bdx; pdy = bdy;
    end
  endtask

  task automatic check_all();
    chk("head_x", head_x, mx[0]);
    chk("head_y", head_y, my[0]);
    chk("length", length, mx.size());
    chk("ate", ate, e_ate);
    chk("game_over", game_over, m_over);
    chk("running", running, m_run);
    chk("q_head", q_head, e_qh);
    chk("q_body", q_body, e_qb);
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic press(input int d);
    b_right = (d == 0); b_left = (d == 1); b_up = (d == 2); b_down = (d == 3);
    step();
    b_right = 1'b0; b_left = 1'b0; b_up = 1'b0; b_down = 1'b0;
  endtask

  initial begin
    int over_cnt;
    int k, tx, ty;
    rst_n = 1'b0; tick = 1'b0;
    b_up = 1'b0; b_down = 1'b0; b_left = 1'b0; b_right = 1'b0;
    ax = '0; ay = '0; av = 1'b0; qx = 4'd7; qy = 4'd7;
    model_reset();
    step();
    step();
    chk("rst_head_x", head_x, 7);
    chk("rst_head_y", head_y, 7);
    chk("rst_length", length, 2);
    chk("rst_running", running, 0);
    chk("rst_q_head", q_head, 0);
    rst_n = 1'b1;

    // Three plain moves to the right.
    press(0);
    chk("start_running", running, 1);
    repeat (3) begin
      do_tick();
      step();
    end
    chk("t1_head_x", head_x, 10);
    chk("t1_length", length, 2);
    qx = 4'd9; qy = 4'd7;
    step();
    chk("t1_q_body_9", q_body, 1);
    qx = 4'd8;
    step();
    chk("t1_q_body_8", q_body, 0);

    // Eat an apple on the first move.
    do_reset();
    ax = 4'd8; ay = 4'd7; av = 1'b1;
    press(0);
    do_tick();
    av = 1'b0;
    chk("eat_ate", ate, 1);
    chk("eat_length", length, 3);
    qx = 4'd8; qy = 4'd7;
    step();
    chk("eat_ate_low", ate, 0);
    chk("eat_q_head", q_head, 1);
    qx = 4'd7;
    step();
    chk("eat_seg1", q_body, 1);
    qx = 4'd6;
    step();
    chk("eat_seg2", q_body, 1);
    qx = 4'd5;
    step();
    chk("eat_beyond", q_body, 0);

    // Reverse press is discarded; a perpendicular press turns.
    press(1);
    do_tick();
    chk("rev_head_x", head_x, 9);
    chk("rev_head_y", head_y, 7);
    press(2);
    do_tick();
    chk("turn_head_x", head_x, 9);
    chk("turn_head_y", head_y, 6);

    // Out-of-grid query.
    qx = 4'd15; qy = 4'd6;
    step();
    chk("offgrid_q", {q_head, q_body}, 0);

    // Right wall.
    do_reset();
    press(0);
    repeat (7) do_tick();
    chk("edge_head_x", head_x, 14);
    do_tick();
`ifdef SNAKE_WRAP_EN
    chk("wrap_head_x", head_x, 0);
    chk("wrap_game_over", game_over, 0);
`else
    chk("wall_head_x", head_x, 14);
    chk("wall_game_over", game_over, 1);
`endif

    // Grow to five, then run a square into the body.
    do_reset();
    press(0);
    for (int x = 8; x <= 10; x++) begin
      ax = CW'(x); ay = 4'd7; av = 1'b1;
      do_tick();
    end
    av = 1'b0;
    chk("sq_length", length, 5);
    press(2); do_tick();
    press(1); do_tick();
    press(3); do_tick();
    chk("sq_game_over", game_over, 1);
    chk("sq_head_x", head_x, 9);
    chk("sq_head_y", head_y, 6);
    repeat (3) do_tick();
    press(0); do_tick();
    chk("sq_frozen_x", head_x, 9);
    chk("sq_frozen_len", length, 5);
    do_reset();
    chk("sq_rst_over", game_over, 0);
    chk("sq_rst_len", length, 2);

    // Fill to the maximum length, then eat once more.
    press(0);
    for (int n = 0; n < 14; n++) begin
      if (mx[0] == 14 && pdx == 1) press(3);
      ax = CW'(mx[0] + pdx); ay = CW'(my[0] + pdy); av = 1'b1;
      do_tick();
    end
    chk("full_length", length, 16);
    press(1);
    ax = 4'd13; ay = 4'd14; av = 1'b1;
    do_tick();
    av = 1'b0;
    chk("full_ate", ate, 1);
    chk("full_length_hold", length, 16);

    // Randomized play.
    do_reset();
    over_cnt = 0;
    for (int n = 0; n < 4000; n++) begin
      rst_n   = ($urandom_range(0, 299) != 0) && (over_cnt < 6);
      b_right = ($urandom_range(0, 9) == 0);
      b_left  = ($urandom_range(0, 9) == 0);
      b_up    = ($urandom_range(0, 9) == 0);
      b_down  = ($urandom_range(0, 9) == 0);
      tick    = ($urandom_range(0, 2) == 0);
      av      = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 0) begin
        tx = mx[0] + pdx; ty = my[0] + pdy;
        ax = CW'(tx); ay = CW'(ty);
      end else begin
        ax = CW'($urandom_range(0, 15)); ay = CW'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1) == 0) begin
        k = $urandom_range(0, mx.size() - 1);
        qx = CW'(mx[k]); qy = CW'(my[k]);
      end else begin
        qx = CW'($urandom_range(0, 15)); qy = CW'($urandom_range(0, 15));
      end
      step();
      over_cnt = m_over ? over_cnt + 1 : 0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
